cache_axi_master: RTL and testbench



---
 rtl/cache_axi_master_if.sv | 64 ++++++
 rtl/cache_axi_master.sv | 134 +++++++++++++
 tb/tb_cache_axi_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_master_if.sv
// Cache-side request/response and AXI4-Lite master signal bundle for cache_axi_master.
// The master modport is the engine's view; the slave modport is the cache controller plus memory side.
interface cache_axi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [ADDR_WIDTH-1:0]   req_wb_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        input  req_valid, req_op, req_addr, req_wb_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wb_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_master.sv
// Single-outstanding AXI4-Lite master serving cache read misses, write-throughs and
// writeback-then-fill requests; one resp_valid pulse per accepted request.
module cache_axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    cache_axi_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    fill_q, fill_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    err_q, err_d;
    logic                    unused_resp_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            fill_q    <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    araddr_d = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    err_d    = 1'b0;
                    fill_d   = (bus.req_op == 2'b10);
                    if (bus.req_op == 2'b01 || bus.req_op == 2'b10) begin
                        awaddr_d  = (bus.req_op == 2'b10) ? bus.req_wb_addr : bus.req_addr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            // AW and W retire independently; the phase ends once neither is still pending.
            WR_REQ: begin
                awvalid_d = awvalid_q && !bus.awready;
                wvalid_d  = wvalid_q && !bus.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    err_d   = err_q | bus.bresp[1];
                    state_d = fill_q ? RD_ADDR : RESP;
                end
            end
            RD_ADDR: begin
                if (bus.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.rvalid) begin
                    rdata_d = bus.rdata;
                    err_d   = err_q | bus.rresp[1];
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = (state_q == RD_ADDR);
    assign bus.rready     = (state_q == RD_DATA);
    assign bus.awaddr     = awaddr_q;
    assign bus.awvalid    = awvalid_q;
    assign bus.wdata      = wdata_q;
    assign bus.wstrb      = '1;
    assign bus.wvalid     = wvalid_q;
    assign bus.bready     = (state_q == WR_RESP);

    // Only the SLVERR/DECERR bit of each response matters to the cache.
    assign unused_resp_bits = ^{bus.bresp[0], bus.rresp[0]};
endmodule

// File: tb/tb_cache_axi_master.sv
// Randomized bench for cache_axi_master: an AXI4-Lite slave model with random stalls
// feeds the DUT, and a per-request reference model predicts bus traffic and the response.
module tb_cache_axi_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic reset;

    cache_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cache_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compared   = 0;
    int mismatched = 0;

    // Slave model controls and logs
    bit          slaveRandom  = 1'b0;
    bit          holdR        = 1'b0;
    int          stallPct     = 0;
    int          maxDelay     = 0;
    int          errPct       = 0;
    int          awForceDelay = -1;
    logic [31:0] fixedRdata   = '0;
    logic [1:0]  fixedRresp   = '0;
    logic [1:0]  fixedBresp   = '0;

    logic [31:0] arLog[$];
    logic [31:0] awLog[$];
    logic [31:0] wLog[$];
    logic [3:0]  wstrbLog[$];
    logic [31:0] rGiven;
    logic [1:0]  rrespGiven;
    logic [1:0]  brespGiven;
    int          rCount, bCount;
    int          rWait = -1, bWait = -1, awHeld = 0;
    bit          awDone, wDone, rHsPend, bHsPend;
    bit          prevArv, prevArHs, prevAwv, prevAwHs, prevWv, prevWHs;
    logic [31:0] prevAraddr, prevAwaddr, prevWdata;
    int          stabViol   = 0;
    int          negCount   = 0;
    int          arRiseNeg  = -1;
    int          bHsNeg     = -1;
    int          respPulses = 0;

    // Driver-side results
    int          respN;
    bit          gotResp;
    logic [31:0] obsRdata;
    bit          obsErr;
    bit          awvTrace[64];
    bit          wvTrace[64];
    logic [31:0] modelRdata = '0;
    int          accepted   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // AXI4-Lite slave: readies and handshake logging are decided at negedge for the next rising edge.
    initial begin
        bit arHs, awHs, wHs;
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.rvalid  = 1'b0; bus.rdata   = '0;   bus.rresp  = '0;
        bus.bvalid  = 1'b0; bus.bresp   = '0;
        forever begin
            @(negedge clk);
            negCount++;
            if (reset) begin
                bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
                bus.rvalid  = 1'b0; bus.bvalid  = 1'b0;
                rWait = -1; bWait = -1; awHeld = 0;
                awDone = 0; wDone = 0; rHsPend = 0; bHsPend = 0;
                prevArv = 0; prevAwv = 0; prevWv = 0;
            end else begin
                if (bus.resp_valid) respPulses++;
                if (prevArv && !prevArHs && (!bus.arvalid || bus.araddr !== prevAraddr)) stabViol++;
                if (prevAwv && !prevAwHs && (!bus.awvalid || bus.awaddr !== prevAwaddr)) stabViol++;
                if (prevWv && !prevWHs && (!bus.wvalid || bus.wdata !== prevWdata)) stabViol++;
                if (bus.arvalid && arRiseNeg < 0) arRiseNeg = negCount;

                if (rHsPend) begin bus.rvalid = 1'b0; rHsPend = 0; end
                if (bHsPend) begin bus.bvalid = 1'b0; bHsPend = 0; end

                if (rWait == 0 && !holdR) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = slaveRandom ? $urandom : fixedRdata;
                    bus.rresp  = slaveRandom ? {($urandom_range(99) < errPct), 1'($urandom_range(1))} : fixedRresp;
                    rWait = -1;
                end else if (rWait > 0) begin
                    rWait--;
                end
                if (bWait == 0) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = slaveRandom ? {($urandom_range(99) < errPct), 1'($urandom_range(1))} : fixedBresp;
                    bWait = -1;
                end else if (bWait > 0) begin
                    bWait--;
                end

                bus.arready = ($urandom_range(99) >= stallPct);
                bus.wready  = ($urandom_range(99) >= stallPct);
                if (awForceDelay >= 0) bus.awready = (awHeld >= awForceDelay);
                else                   bus.awready = ($urandom_range(99) >= stallPct);

                arHs = bus.arvalid && bus.arready;
                awHs = bus.awvalid && bus.awready;
                wHs  = bus.wvalid && bus.wready;
                if (arHs) begin
                    arLog.push_back(bus.araddr);
                    rWait = $urandom_range(maxDelay);
                end
                if (awHs) begin
                    awLog.push_back(bus.awaddr);
                    awDone = 1; awHeld = 0;
                end else if (bus.awvalid) begin
                    awHeld++;
                end
                if (wHs) begin
                    wLog.push_back(bus.wdata);
                    wstrbLog.push_back(bus.wstrb);
                    wDone = 1;
                end
                if (awDone && wDone) begin
                    bWait = $urandom_range(maxDelay);
                    awDone = 0; wDone = 0;
                end
                if (bus.rvalid && bus.rready) begin
                    rHsPend = 1; rGiven = bus.rdata; rrespGiven = bus.rresp; rCount++;
                end
                if (bus.bvalid && bus.bready) begin
                    bHsPend = 1; brespGiven = bus.bresp; bCount++; bHsNeg = negCount;
                end

                prevArv = bus.arvalid; prevArHs = arHs; prevAraddr = bus.araddr;
                prevAwv = bus.awvalid; prevAwHs = awHs; prevAwaddr = bus.awaddr;
                prevWv  = bus.wvalid;  prevWHs  = wHs;  prevWdata  = bus.wdata;
            end
        end
    end

    // Issues one request at a negedge (DUT idle), waits for the completion, then checks it against the model.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wbAddr,
                                 input logic [31:0] wdata, input bit holdValid);
        bit          readyLow;
        bit          hasWrite, hasRead, expErr;
        logic [31:0] expAw;
        arLog.delete(); awLog.delete(); wLog.delete(); wstrbLog.delete();
        rCount = 0; bCount = 0; arRiseNeg = -1; bHsNeg = -1;
        rrespGiven = '0; brespGiven = '0;
        foreach (awvTrace[i]) begin awvTrace[i] = 0; wvTrace[i] = 0; end

        checkOutput("idleReady", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
        bus.req_wb_addr = wbAddr; bus.req_wdata = wdata;
        accepted++;
        gotResp = 0; readyLow = 1; respN = 0;
        for (int n = 1; n <= 200 && !gotResp; n++) begin
            @(negedge clk);
            if (n < 64) begin awvTrace[n] = bus.awvalid; wvTrace[n] = bus.wvalid; end
            if (n == 1) begin
                if (!holdValid) bus.req_valid = 1'b0;
                bus.req_op = 2'($urandom_range(3)); bus.req_addr = $urandom;
                bus.req_wb_addr = $urandom; bus.req_wdata = $urandom;
            end
            if (bus.resp_valid) begin
                gotResp = 1; respN = n;
                obsRdata = bus.resp_rdata; obsErr = bus.resp_err;
                bus.req_valid = 1'b0;
            end else if (bus.req_ready) begin
                readyLow = 0;
            end
        end
        checkOutput("respTimeout", gotResp, 1);
        @(negedge clk);
        checkOutput("respPulse", {bus.resp_valid, bus.req_ready}, 2'b01);
        if (holdValid) checkOutput("readyLowBusy", readyLow, 1);

        hasWrite = (op == 2'b01) || (op == 2'b10);
        hasRead  = (op != 2'b01);
        expAw    = (op == 2'b10) ? wbAddr : addr;
        expErr   = (hasWrite && brespGiven[1]) || (hasRead && rrespGiven[1]);
        if (hasRead && rCount > 0) modelRdata = rGiven;

        checkOutput("arCount", arLog.size(), hasRead);
        if (hasRead && arLog.size() > 0) checkOutput("araddr", arLog[0], addr);
        checkOutput("awCount", awLog.size(), hasWrite);
        checkOutput("wCount", wLog.size(), hasWrite);
        if (hasWrite && awLog.size() > 0) checkOutput("awaddr", awLog[0], expAw);
        if (hasWrite && wLog.size() > 0) begin
            checkOutput("wdata", wLog[0], wdata);
            checkOutput("wstrb", wstrbLog[0], 4'hF);
        end
        checkOutput("rdata", obsRdata, modelRdata);
        checkOutput("respErr", obsErr, expErr);
        if (op == 2'b10) checkOutput("wbToFillGap", arRiseNeg - bHsNeg, 1);
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0;
        bus.req_wb_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstCtrl", {bus.req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                                bus.bready, bus.resp_valid, bus.resp_err}, 8'b1000_0000);
        checkOutput("rstRdata", bus.resp_rdata, 0);
        checkOutput("rstAddr", {bus.araddr, bus.awaddr}, 0);
        checkOutput("rstWdata", bus.wdata, 0);
        reset = 1'b0;
        @(negedge clk);

        fixedRdata = 32'hDEADBEEF;
        applyStimulus(2'b00, 32'h10, 32'h0, 32'h0, 0);
        checkOutput("rdLatency", respN, 3);
        checkOutput("rdDeadbeef", obsRdata, 32'hDEADBEEF);

        awForceDelay = 3;
        applyStimulus(2'b01, 32'h20, 32'h0, 32'h12345678, 0);
        awForceDelay = -1;
        checkOutput("wvDrop", {wvTrace[1], wvTrace[2]}, 2'b10);
        checkOutput("awvHold", {awvTrace[4], awvTrace[5]}, 2'b10);

        applyStimulus(2'b01, 32'h24, 32'h0, 32'hA5A5_5A5A, 0);
        checkOutput("wrLatency", respN, 3);

        fixedRdata = 32'hCAFEF00D;
        applyStimulus(2'b10, 32'h200, 32'h100, 32'h0000_55AA, 0);
        checkOutput("wbLatency", respN, 5);

        fixedBresp = 2'b10;
        applyStimulus(2'b10, 32'h300, 32'h180, 32'h1357_9BDF, 0);
        checkOutput("wbErrFlag", obsErr, 1);
        fixedBresp = 2'b00;

        fixedRdata = 32'h0BAD_F00D;
        applyStimulus(2'b00, 32'h400, 32'h0, 32'h0, 1);

        fixedRresp = 2'b11;
        applyStimulus(2'b11, 32'h404, 32'h0, 32'h0, 0);
        fixedRresp = 2'b00;

        holdR = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_addr = 32'h40;
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (bus.rready) seen = 1;
            else @(negedge clk);
        end
        checkOutput("reachRdData", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstMidTxn", {bus.arvalid, bus.rready, bus.resp_valid, bus.req_ready,
                                  bus.awvalid, bus.wvalid, bus.bready}, 7'b0001000);
        @(negedge clk);
        reset = 1'b0;
        holdR = 1'b0;
        @(negedge clk);
        fixedRdata = 32'h7777_1234;
        applyStimulus(2'b00, 32'h44, 32'h0, 32'h0, 0);

        slaveRandom = 1'b1; stallPct = 30; maxDelay = 3; errPct = 25;
        for (int t = 0; t < 40; t++) begin
            applyStimulus(2'($urandom_range(3)), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                          $urandom, ($urandom_range(3) == 0));
        end

        checkOutput("axiStable", stabViol, 0);
        checkOutput("respTotal", respPulses, accepted);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
